// File: rtl/popcount_inv_enum_int8.sv
// Enumerates every 8-bit word with popcount K in increasing order, one per
// valid/ready handshake, framed by last/done; out-of-range K pulses err.
module popcount_inv_enum_int8 #(
  parameter int WIDTH     = 8,
  parameter int IMPL_TYPE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       K,
  input  logic             abort,
  output logic             busy,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] Y,
  output logic [6:0]       idx,
  output logic             last,
  output logic             done,
  output logic             err
);

  localparam logic [3:0] KMAX = 4'(WIDTH);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [6:0]         idx_q, idx_d, idx_inc;
  logic [3:0]         k_q, k_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               last_w;

  // k ones packed into the LSBs: the first word of an enumeration
  function automatic logic [WIDTH-1:0] low_mask(input logic [3:0] k);
    logic [WIDTH-1:0] m;
    for (int i = 0; i < WIDTH; i++) m[i] = (i < int'(k));
    return m;
  endfunction

  // k ones packed into the MSBs: the final word of an enumeration
  function automatic logic [WIDTH-1:0] high_mask(input logic [3:0] k);
    logic [WIDTH-1:0] m;
    for (int i = 0; i < WIDTH; i++) m[i] = (i >= WIDTH - int'(k));
    return m;
  endfunction

  // Next larger word of equal popcount; result is unused once y is the last word
  function automatic logic [WIDTH-1:0] gosper_next(input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] c, r, ones;
    int               tz;
    c  = y & (~y + {{(WIDTH-1){1'b0}}, 1'b1});
    r  = y + c;
    tz = 0;
    for (int i = WIDTH - 1; i >= 0; i--) if (c[i]) tz = i;
    ones = ((r ^ y) >> 2) >> tz;
    return ones | r;
  endfunction

  generate
    if (IMPL_TYPE == 0) begin : g_inc_add
      assign idx_inc = idx_q + 7'd1;
    end else begin : g_inc_sub
      // modular subtract of 127 is the same +1 in 7 bits
      assign idx_inc = idx_q - 7'h7F;
    end
  endgenerate

  assign last_w = (state_q == EMIT) && (y_q == high_mask(k_q));

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    idx_d   = idx_q;
    k_d     = k_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (K > KMAX) begin
            err_d = 1'b1;
          end else begin
            state_d = EMIT;
            k_d     = K;
            y_d     = low_mask(K);
            idx_d   = 7'd0;
          end
        end
      end
      EMIT: begin
        // abort beats any coincident handshake: no successor, no done
        if (abort) begin
          state_d = IDLE;
        end else if (ready) begin
          if (last_w) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            y_d   = gosper_next(y_q);
            idx_d = idx_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      idx_q   <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      k_q     <= k_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy  = (state_q == EMIT);
  assign valid = (state_q == EMIT);
  assign Y     = y_q;
  assign idx   = idx_q;
  assign last  = last_w;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_popcount_inv_enum_int8.sv
// Scoreboard bench: expected words come from scanning all 256 values for
// popcount K; a monitor pops and compares on every handshake.
module tb_popcount_inv_enum_int8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] K = 4'd0;
  logic       abort = 1'b0;
  logic       busy, valid, last, done, err;
  logic       ready = 1'b0;
  logic [7:0] Y;
  logic [6:0] idx;

  typedef struct packed {
    logic [7:0] y;
    logic [6:0] idx;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   hs_cnt = 0;
  int   done_cnt = 0;

  popcount_inv_enum_int8 #(.WIDTH(8), .IMPL_TYPE(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .K(K), .abort(abort),
    .busy(busy), .valid(valid), .ready(ready), .Y(Y), .idx(idx),
    .last(last), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at %0t", name, act, act, req, req, $time);
    end
  endtask

  // Monitor: samples on the falling edge, inputs change 2 units after rising
  initial begin
    bit         hs_last_prev = 0, stall_prev = 0, abort_prev = 0;
    logic [7:0] y_prev = 0;
    logic [6:0] idx_prev = 0;
    logic       last_prev = 0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hs_last_prev = 0; stall_prev = 0; abort_prev = 0;
      end else begin
        check(done == hs_last_prev, "done_pulse", int'(done), int'(hs_last_prev));
        if (done) begin
          done_cnt++;
          check(!busy && !valid, "idle_on_done", int'(busy), 0);
        end
        check(!(done && err), "done_err_excl", int'(done && err), 0);
        if (stall_prev && !abort_prev) begin
          check(valid == 1'b1, "stall_valid", int'(valid), 1);
          check(Y == y_prev, "stall_Y", int'(Y), int'(y_prev));
          check(idx == idx_prev, "stall_idx", int'(idx), int'(idx_prev));
          check(last == last_prev, "stall_last", int'(last), int'(last_prev));
        end
        if (valid && ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_word", int'(Y), -1);
          end else begin
            e = exp_q.pop_front();
            check(Y == e.y, "word_Y", int'(Y), int'(e.y));
            check(idx == e.idx, "word_idx", int'(idx), int'(e.idx));
            check(last == e.last, "word_last", int'(last), int'(e.last));
          end
        end
        hs_last_prev = valid && ready && last && !abort;
        stall_prev   = valid && !ready;
        abort_prev   = abort;
        y_prev = Y; idx_prev = idx; last_prev = last;
      end
    end
  end

  task automatic check_cleared(input string tag);
    check(!valid && !busy && !done && !err && !last, {tag, "_ctrl"},
          int'({valid, busy, done, err, last}), 0);
    check(Y == 8'h00, {tag, "_Y"}, int'(Y), 0);
    check(idx == 7'd0, {tag, "_idx"}, int'(idx), 0);
  endtask

  // Runs one enumeration; optional abort after word abort_at is accepted,
  // stray start after inject_at words, or reset after rst_at words.
  task automatic run_enum(input int k, input bit rnd, input int abort_at,
                          input int inject_at, input int rst_at);
    int   cnt, i, base_hs, base_done, n;
    bit   stop_abort, stop_rst;
    logic [7:0] wv;
    cnt = 0;
    for (int w = 0; w < 256; w++) begin
      wv = 8'(w);
      if ($countones(wv) == k) cnt++;
    end
    i = 0;
    for (int w = 0; w < 256; w++) begin
      wv = 8'(w);
      if ($countones(wv) == k) begin
        exp_q.push_back('{y: wv, idx: 7'(i), last: (i == cnt - 1)});
        i++;
      end
    end
    base_hs = hs_cnt; base_done = done_cnt;
    @(posedge clk); #2;
    start = 1'b1; K = 4'(k); ready = 1'b1;
    @(posedge clk); #2;
    K = 4'($urandom_range(0, 15));
    n = 0; stop_abort = 0; stop_rst = 0;
    while (!stop_abort && !stop_rst && done_cnt == base_done && n < 1000) begin
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = 1'b0; abort = 1'b0;
      if (inject_at >= 0 && hs_cnt - base_hs == inject_at) start = 1'b1;
      if (abort_at >= 0 && hs_cnt - base_hs == abort_at + 1) begin
        ready = 1'b0; abort = 1'b1; stop_abort = 1;
      end
      if (rst_at >= 0 && hs_cnt - base_hs == rst_at) begin
        stop_rst = 1;
      end else begin
        @(posedge clk); #2;
        n++;
      end
    end
    start = 1'b0;
    if (stop_abort) begin
      abort = 1'b0;
      check(!valid && !busy, "abort_idle", int'({valid, busy}), 0);
      @(posedge clk); #2;
      check(!done && !valid, "abort_no_done", int'({done, valid}), 0);
      exp_q.delete();
    end else if (stop_rst) begin
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_cleared("midrst");
      exp_q.delete();
      @(negedge clk); #1;
      rst_n = 1'b1;
    end else begin
      check(done_cnt != base_done, "enum_timeout", n, 1000);
      check(exp_q.size() == 0, "words_left", exp_q.size(), 0);
      exp_q.delete();
    end
    ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic err_test(input int k);
    @(posedge clk); #2;
    start = 1'b1; K = 4'(k);
    @(posedge clk); #2;
    start = 1'b0;
    check(err == 1'b1, "err_pulse", int'(err), 1);
    check(!valid && !busy, "err_no_valid", int'({valid, busy}), 0);
    @(posedge clk); #2;
    check(err == 1'b0, "err_one_cycle", int'(err), 0);
    check(!valid && !busy, "err_stay_idle", int'({valid, busy}), 0);
  endtask

  initial begin
    #12;
    check_cleared("reset");
    @(negedge clk); #1;
    rst_n = 1'b1;
    run_enum(2, 0, -1, -1, -1);
    run_enum(0, 0, -1, -1, -1);
    run_enum(8, 0, -1, -1, -1);
    run_enum(4, 0, -1, -1, -1);
    err_test(9);
    err_test(15);
    run_enum(3, 1, -1, -1, -1);
    run_enum(4, 0, 10, -1, -1);
    run_enum(1, 0, -1, -1, -1);
    run_enum(5, 0, -1, -1, 6);
    run_enum(5, 0, -1, 3, -1);
    for (int t = 0; t < 4; t++) run_enum(int'($urandom_range(0, 8)), 1, -1, -1, -1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
